// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: payload width default and
// the drain state machine encoding used by uart_tx_fifo.
package uart_pkg;

  localparam int unsigned UART_PAYLOAD_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } drain_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side push bus, status flags and uart_tx-side start bus of uart_tx_fifo.
// The slave modport is the FIFO's view; the master modport is the surrounding logic's view.
interface uart_tx_fifo_if #(
  parameter int unsigned PAYLOAD_BITS = uart_pkg::UART_PAYLOAD_BITS,
  parameter int unsigned DEPTH        = 16
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [PAYLOAD_BITS-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    overflow_clr;
  logic                    overflow;
  logic [ADDR_W:0]         count;
  logic                    empty;
  logic                    full;
  logic                    uart_tx_busy;
  logic                    uart_tx_en;
  logic [PAYLOAD_BITS-1:0] uart_tx_data;

  modport slave (
    input  in_data, in_valid, overflow_clr, uart_tx_busy,
    output in_ready, overflow, count, empty, full, uart_tx_en, uart_tx_data
  );

  modport master (
    output in_data, in_valid, overflow_clr, uart_tx_busy,
    input  in_ready, overflow, count, empty, full, uart_tx_en, uart_tx_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage array, wrapping pointers and an occupancy counter.
// Writes when full and reads when empty are ignored, so count stays in 0..DEPTH.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_rd;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_wr    = i_wr_en && !w_full;
  assign w_rd    = i_rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = w_full;
  assign o_empty   = w_empty;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of uart_tx: accepts words on a valid/ready bus and
// drains them one frame at a time with a registered single-cycle start pulse.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = UART_PAYLOAD_BITS,
  parameter int unsigned DEPTH        = 16
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_fifo_if.slave   bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [ADDR_W:0]         w_count;
  logic [PAYLOAD_BITS-1:0] w_head;

  drain_state_t            r_state;
  logic                    r_tx_en;
  logic [PAYLOAD_BITS-1:0] r_tx_data;
  logic                    r_overflow;

  // in_ready is !full only, so a pop in the same cycle never admits a push into a full FIFO.
  assign w_push = bus.in_valid && !w_full;
  assign w_pop  = (r_state == ST_IDLE) && !w_empty && !bus.uart_tx_busy;

  sync_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_push),
    .i_wr_data (bus.in_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_tx_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_tx_data <= w_head;
            r_tx_en   <= 1'b1;
            r_state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (bus.uart_tx_busy) begin
            r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.uart_tx_busy) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // A new overflow takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (bus.in_valid && w_full) begin
      r_overflow <= 1'b1;
    end else if (bus.overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.in_ready     = !w_full;
  assign bus.overflow     = r_overflow;
  assign bus.count        = w_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.uart_tx_en   = r_tx_en;
  assign bus.uart_tx_data = r_tx_data;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer that sits directly upstream of `uart_tx` and lets a producer push bursts of payload words faster than the line rate. Words are written with a valid/ready handshake into a synchronous FIFO. A drain state machine pops one word at a time and issues a single-cycle `uart_tx_en` whenever the transmitter is idle. It replaces the direct `uart_rx_valid` → `uart_tx_en` wiring in the echo top level, so back-to-back received bytes are never dropped while `uart_tx` is busy.

## Interface
- `PAYLOAD_BITS`, 8, width of each buffered word; must match `uart_tx`.
- `DEPTH`, 16, FIFO entries; power of two, at least 2.
- `ADDR_W`, $clog2(DEPTH), pointer width; derived, not overridden.

- `clk`  input  1  system clock.
- `reset`  input  1  synchronous, active-low.
- `in_data`  input  PAYLOAD_BITS  word to enqueue.
- `in_valid`  input  1  producer offers `in_data` this cycle.
- `in_ready`  output  1  FIFO can accept; equals !full.
- `overflow_clr`  input  1  clears the sticky `overflow` flag.
- `overflow`  output  1  sticky; set when `in_valid` is high while full.
- `count`  output  ADDR_W+1  words currently stored, range 0..DEPTH.
- `empty`  output  1  count == 0.
- `full`  output  1  count == DEPTH.
- `uart_tx_busy`  input  1  from `uart_tx`.
- `uart_tx_en`  output  1  one-cycle start pulse to `uart_tx`.
- `uart_tx_data`  output  PAYLOAD_BITS  word being sent; held stable until the transmitter finishes.

## Operation
- Push: when `in_valid && in_ready` is high at a rising edge, `in_data` is written at `wr_ptr` and `wr_ptr` increments, wrapping modulo DEPTH.
- Overflow: `in_valid` while full drops the word, leaves the FIFO unchanged and sets `overflow`.
  - `overflow_clr` clears it.
  - If a set and a clear happen in the same cycle, the set wins.
- Drain FSM, 4 states:
  - IDLE: if !empty and !`uart_tx_busy`, register the head word into `uart_tx_data`, increment `rd_ptr` and go to SEND.
  - SEND: assert `uart_tx_en` for exactly this cycle, then go to WAIT_ACK.
  - WAIT_ACK: stay until `uart_tx_busy` == 1, then go to WAIT_DONE.
  - WAIT_DONE: stay until `uart_tx_busy` == 0, then go to IDLE.
- `count` arithmetic: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- `count` is never allowed outside 0..DEPTH.
- Push while full is rejected even if a pop happens in the same cycle, because `in_ready` depends on `full` only and has no combinational path from the pop.
- Simultaneous push into an empty FIFO with IDLE evaluating: the pop sees the pre-edge empty state, so that word is popped on the next cycle.
- Reset mid-operation: pointers, `count`, FSM and `overflow` return to reset state and buffered words are discarded. `uart_tx` shares `reset`, so any in-flight frame is aborted consistently.

## Timing
- Reset values:
  - `in_ready`=1, `empty`=1, `full`=0, `count`=0.
  - `overflow`=0, `uart_tx_en`=0, `uart_tx_data`=0.
  - FSM in IDLE, `rd_ptr`=`wr_ptr`=0.
- All outputs are registered or derived from registered state only; there are no combinational input-to-output paths.
- Latency: a word pushed at edge N into an empty FIFO with the transmitter idle gives:
  - `uart_tx_data` valid after edge N+1;
  - `uart_tx_en` high in the cycle between edges N+1 and N+2.
- `uart_tx` raises busy the cycle after `uart_tx_en`.
- Minimum word-to-word spacing is the frame time plus 3 clocks: WAIT_DONE to IDLE, IDLE to SEND, then SEND.
- `uart_tx_data` changes only on the IDLE to SEND transition.

## Structure
- Shared package `uart_pkg`:
  - `PAYLOAD_BITS` default;
  - the drain FSM state typedef (IDLE, SEND, WAIT_ACK, WAIT_DONE), 2-bit binary encoding.
- Sub-module `sync_fifo` contains the storage array, `wr_ptr`/`rd_ptr`, `count`, `full` and `empty`, parameterised by width and depth.
- `uart_tx_fifo` instantiates it and contains the drain FSM and the overflow logic.
- The echo top level instantiates `uart_tx_fifo` between `uart_rx` and `uart_tx`.

## Test plan
- Single word: push 0x55 with the transmitter idle → `uart_tx_en` pulses 2 cycles later with `uart_tx_data`=0x55, and `count` goes 1 → 0.
- Burst: push 0x01..0x10 on 16 consecutive cycles (DEPTH=16) while busy is modelled → all 16 are transmitted in order, one `uart_tx_en` per frame, and `full` is seen once 16 words are queued.
- Overflow: with the FIFO full, drive `in_valid` carrying 0xAA → word not stored, `overflow`=1, `count`=16, `in_ready`=0. Then `overflow_clr` → `overflow`=0.
- Pointer wrap: 40 words streamed at line rate with interleaved push and pop → output sequence equals input sequence across the pointer wrap, and `count` never exceeds DEPTH.
- Simultaneous push and pop at count=5 → `count` stays 5 and ordering is preserved.
- Reset mid-burst: assert reset low for 1 cycle with 7 words queued and FSM in WAIT_DONE → `count`=0, `empty`=1, `uart_tx_en`=0, FSM in IDLE, and no stale word is sent afterwards.
